ising_anneal_sequencer: RTL and testbench

Step-level controller for the oscillator Ising datapath. It runs the annealing loop: it issues one force-evaluation request per oscillator to the force engine over a valid/ready handshake and counts the returned results. After a full sweep it fires a single phase-update strobe and advances the coupling gain K and the self-stabilisation gain Ks along a linear, clamped schedule, repeating for a programmed number of steps. It sits between the host start/abort interface and the force/phase-update datapath, and it owns all loop sequencing.

---
 rtl/ising_anneal_sequencer_if.sv | 26 ++
 rtl/ising_anneal_sequencer.sv | 159 +++++++++++++++
 tb/tb_ising_anneal_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ising_anneal_sequencer_if.sv
// Force-engine request/response channel between the anneal
// sequencer (master) and the force evaluation datapath (slave).
interface ising_anneal_sequencer_if #(
  parameter int N = 16
);
  localparam int IW = $clog2(N);

  logic          force_req_valid;
  logic [IW-1:0] force_req_idx;
  logic          force_req_ready;
  logic          force_rsp_valid;

  modport master (
    output force_req_valid,
    output force_req_idx,
    input  force_req_ready,
    input  force_rsp_valid
  );

  modport slave (
    input  force_req_valid,
    input  force_req_idx,
    output force_req_ready,
    output force_rsp_valid
  );
endinterface

// File: rtl/ising_anneal_sequencer.sv
// Annealing loop controller: per-sweep force requests, response
// counting, phase-update strobe and linear clamped gain schedule.
module ising_anneal_sequencer #(
  parameter int N          = 16,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int STEP_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [STEP_W-1:0]     num_steps,
  input  logic [DATA_WIDTH-1:0] k_inc,
  input  logic [DATA_WIDTH-1:0] ks_inc,
  input  logic [DATA_WIDTH-1:0] ks_max,
  ising_anneal_sequencer_if.master fr,
  output logic                  upd_pulse,
  output logic [DATA_WIDTH-1:0] k_out,
  output logic [DATA_WIDTH-1:0] ks_out,
  output logic [STEP_W-1:0]     step_count,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  rsp_overflow
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam int DW = DATA_WIDTH;
  localparam logic [DW-1:0] ONE = DW'(1) << FRAC_BITS;
  localparam logic [DW-1:0] K_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] K_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, ISSUE, DRAIN, UPDATE, DONE
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]     idx_q;
  logic [CW-1:0]     rsp_cnt_q;
  logic [STEP_W-1:0] steps_q;
  logic [STEP_W-1:0] step_q;
  logic [STEP_W-1:0] step_next;
  logic [DW-1:0]     k_q, ks_q;
  logic [DW-1:0]     k_inc_q, ks_inc_q, ks_max_q;
  logic              aborted_q, ovf_q;

  logic          in_run;
  logic          rsp_full;
  logic          count_en;
  logic [DW:0]   k_sum;
  logic [DW-1:0] k_next;
  logic [DW+1:0] ks_sum, ks_lim;
  logic [DW-1:0] ks_next;

  assign in_run    = (state_q != IDLE);
  assign rsp_full  = (rsp_cnt_q == CW'(N));
  assign count_en  = fr.force_rsp_valid && !rsp_full &&
                     (state_q == ISSUE || state_q == DRAIN);
  assign step_next = step_q + 1'b1;

  // K saturates on signed overflow of the add
  assign k_sum = {k_q[DW-1], k_q} + {k_inc_q[DW-1], k_inc_q};
  always_comb begin
    k_next = k_sum[DW-1:0];
    if (k_sum[DW] != k_sum[DW-1])
      k_next = k_sum[DW] ? K_MIN : K_MAX;
  end

  // Ks grows by an unsigned step; two guard bits keep the add exact
  assign ks_sum  = {{2{ks_q[DW-1]}}, ks_q} + {2'b00, ks_inc_q};
  assign ks_lim  = {{2{ks_max_q[DW-1]}}, ks_max_q};
  assign ks_next = ($signed(ks_sum) > $signed(ks_lim))
                 ? ks_max_q : ks_sum[DW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start)
          state_d = (num_steps == '0) ? DONE : ISSUE;
      ISSUE:
        if (fr.force_req_ready && idx_q == IW'(N-1))
          state_d = DRAIN;
      DRAIN:
        if (rsp_full ||
            (rsp_cnt_q == CW'(N-1) && fr.force_rsp_valid))
          state_d = UPDATE;
      UPDATE:
        state_d = (step_next == steps_q) ? DONE : ISSUE;
      DONE:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
    if (abort && in_run) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      rsp_cnt_q <= '0;
      steps_q   <= '0;
      step_q    <= '0;
      k_q       <= ONE;
      ks_q      <= ONE;
      k_inc_q   <= '0;
      ks_inc_q  <= '0;
      ks_max_q  <= '0;
      aborted_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      aborted_q <= abort && in_run;
      if (in_run && fr.force_rsp_valid && rsp_full)
        ovf_q <= 1'b1;
      if (state_q == IDLE && start) begin
        steps_q   <= num_steps;
        k_inc_q   <= k_inc;
        ks_inc_q  <= ks_inc;
        ks_max_q  <= ks_max;
        k_q       <= ONE;
        ks_q      <= ONE;
        step_q    <= '0;
        idx_q     <= '0;
        rsp_cnt_q <= '0;
        ovf_q     <= 1'b0;
      end
      if (state_q == ISSUE && fr.force_req_ready)
        idx_q <= idx_q + 1'b1;
      if (count_en)
        rsp_cnt_q <= rsp_cnt_q + 1'b1;
      if (state_q == UPDATE && !abort) begin
        step_q    <= step_next;
        k_q       <= k_next;
        ks_q      <= ks_next;
        idx_q     <= '0;
        rsp_cnt_q <= '0;
      end
    end
  end

  assign fr.force_req_valid = (state_q == ISSUE);
  assign fr.force_req_idx   = idx_q;
  assign upd_pulse          = (state_q == UPDATE);
  assign busy               = in_run;
  assign done               = (state_q == DONE);
  assign aborted            = aborted_q;
  assign rsp_overflow       = ovf_q;
  assign k_out              = k_q;
  assign ks_out             = ks_q;
  assign step_count         = step_q;

endmodule

// File: tb/tb_ising_anneal_sequencer.sv
// Randomized bench for ising_anneal_sequencer with a behavioural
// force engine and an arithmetic gain-schedule model.
module tb_ising_anneal_sequencer;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] num_steps = '0;
  logic [31:0] k_inc = '0, ks_inc = '0, ks_max = '0;
  logic        upd_pulse, busy, done, aborted, rsp_overflow;
  logic [31:0] k_out, ks_out;
  logic [15:0] step_count;

  always #5 clk = ~clk;

  ising_anneal_sequencer_if #(.N(N)) fr();

  ising_anneal_sequencer #(
    .N(N), .DATA_WIDTH(32), .FRAC_BITS(16), .STEP_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_steps(num_steps), .k_inc(k_inc), .ks_inc(ks_inc),
    .ks_max(ks_max), .fr(fr), .upd_pulse(upd_pulse),
    .k_out(k_out), .ks_out(ks_out), .step_count(step_count),
    .busy(busy), .done(done), .aborted(aborted),
    .rsp_overflow(rsp_overflow)
  );

  int nvec = 0, nerr = 0;
  int cyc = 0, t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int lat = 1, rmode = 0;
  bit extra_pend = 0;
  int rsp_q[$], acc_idx[$], acc_cyc[$];
  int upd_cyc[$], upd_rsp[$], upd_sc[$];
  logic [31:0] upd_k[$], upd_ks[$];
  int done_cnt = 0, done_cyc = -1, abort_cnt = 0;
  int hold_err = 0, rsp_in_step = 0, hold_idx = 0;
  bit post_busy = 0, prev_done = 0, prev_upd = 0, hold_pend = 0;
  bit timed_out = 0;

  // Force engine: fixed latency per accepted request, one pulse per cycle
  always @(negedge clk) begin : engine
    int c;
    c = cyc - t0;
    if (prev_upd) begin
      upd_k.push_back(k_out);
      upd_ks.push_back(ks_out);
      upd_sc.push_back(int'(step_count));
    end
    prev_upd = upd_pulse;
    if (prev_done) post_busy = busy;
    prev_done = done;
    case (rmode)
      1:       fr.force_req_ready = c[0];
      2:       fr.force_req_ready = ($urandom % 4) != 0;
      default: fr.force_req_ready = 1'b1;
    endcase
    if (hold_pend && (!fr.force_req_valid ||
        int'(fr.force_req_idx) != hold_idx))
      hold_err++;
    hold_pend = fr.force_req_valid && !fr.force_req_ready;
    hold_idx = int'(fr.force_req_idx);
    if (fr.force_req_valid && fr.force_req_ready) begin
      acc_idx.push_back(int'(fr.force_req_idx));
      acc_cyc.push_back(c);
      rsp_q.push_back(c + lat);
    end
    if (upd_pulse) begin
      upd_cyc.push_back(c);
      upd_rsp.push_back(rsp_in_step);
      rsp_in_step = 0;
    end
    if (done) begin
      done_cnt++;
      done_cyc = c;
    end
    if (aborted) abort_cnt++;
    fr.force_rsp_valid = 1'b0;
    if (rsp_q.size() > 0 && rsp_q[0] <= c) begin
      void'(rsp_q.pop_front());
      fr.force_rsp_valid = 1'b1;
      rsp_in_step++;
    end else if (extra_pend && upd_pulse) begin
      fr.force_rsp_valid = 1'b1;
      extra_pend = 0;
      rsp_in_step++;
    end
  end

  function automatic logic [31:0] ref_k(input logic [31:0] inc,
                                        input int s);
    longint k, hi, lo;
    logic [63:0] r;
    k = 65536;
    hi = 64'sd2147483647;
    lo = -hi - 1;
    for (int i = 0; i < s; i++) begin
      k = k + longint'(signed'(inc));
      if (k > hi) k = hi;
      if (k < lo) k = lo;
    end
    r = k;
    return r[31:0];
  endfunction

  function automatic logic [31:0] ref_ks(input logic [31:0] inc,
                                         input logic [31:0] mx,
                                         input int s);
    longint ks, lim;
    logic [63:0] r;
    ks = 65536;
    lim = longint'(signed'(mx));
    for (int i = 0; i < s; i++) begin
      ks = ks + longint'(inc);
      if (ks > lim) ks = lim;
    end
    r = ks;
    return r[31:0];
  endfunction

  task automatic run(input int ns, input logic [31:0] ki,
                     input logic [31:0] ksi, input logic [31:0] ksm,
                     input int l, input int rm, input int rst_c,
                     input int ab_acc, input bit ex);
    int n;
    bit fired;
    @(negedge clk); #1;
    rsp_q.delete(); acc_idx.delete(); acc_cyc.delete();
    upd_cyc.delete(); upd_rsp.delete(); upd_sc.delete();
    upd_k.delete(); upd_ks.delete();
    done_cnt = 0; done_cyc = -1; abort_cnt = 0; hold_err = 0;
    rsp_in_step = 0; post_busy = 1; hold_pend = 0;
    lat = l; rmode = rm; extra_pend = ex;
    timed_out = 0; fired = 0; n = 0;
    num_steps = ns[15:0]; k_inc = ki; ks_inc = ksi; ks_max = ksm;
    start = 1'b1;
    t0 = cyc;
    forever begin
      @(negedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      num_steps = ns[15:0];
      if (cyc - t0 == rst_c) begin
        start = 1'b1;
        num_steps = ns[15:0] + 16'd5;
      end
      if (ab_acc > 0 && !fired && acc_idx.size() == ab_acc &&
          !fr.force_req_valid && busy && !upd_pulse) begin
        abort = 1'b1;
        fired = 1;
      end
      if ((done_cnt > 0 || abort_cnt > 0) && !busy) break;
      n++;
      if (n > 2000) begin
        timed_out = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    nvec++; if (k_out !== 32'h00010000) begin nerr++; $display("FAIL reset_k got %h exp %h", k_out, 32'h00010000); end
    nvec++; if (ks_out !== 32'h00010000) begin nerr++; $display("FAIL reset_ks got %h exp %h", ks_out, 32'h00010000); end
    nvec++; if (step_count !== 16'd0) begin nerr++; $display("FAIL reset_steps got %0d exp 0", step_count); end
    nvec++; if ({busy, done, aborted, rsp_overflow, upd_pulse} !== 5'b0) begin nerr++; $display("FAIL reset_flags got %b exp 00000", {busy, done, aborted, rsp_overflow, upd_pulse}); end
    nvec++; if ({fr.force_req_valid, fr.force_req_idx} !== 5'b0) begin nerr++; $display("FAIL reset_req got %b exp 00000", {fr.force_req_valid, fr.force_req_idx}); end
  endtask

  task automatic test_single_step();
    int bad;
    run(1, 32'h1000, 32'h0, 32'h7FFFFFFF, 1, 0, 0, 0, 0);
    nvec++; if (timed_out) begin nerr++; $display("FAIL single_timeout got 1 exp 0"); end
    bad = (acc_idx.size() != N);
    for (int i = 0; i < acc_idx.size(); i++)
      if (acc_idx[i] != i || acc_cyc[i] != i + 1) bad++;
    nvec++; if (bad != 0) begin nerr++; $display("FAIL single_issue got %0d errors (%0d reqs) exp 0", bad, acc_idx.size()); end
    nvec++; if (upd_cyc.size() != 1 || upd_cyc[0] != 18) begin nerr++; $display("FAIL single_upd_cycle got %0d exp 18", upd_cyc.size() ? upd_cyc[0] : -1); end
    nvec++; if (done_cyc != 19) begin nerr++; $display("FAIL single_done_cycle got %0d exp 19", done_cyc); end
    nvec++; if (post_busy !== 1'b0) begin nerr++; $display("FAIL single_busy_fall got %b exp 0", post_busy); end
    nvec++; if (k_out !== 32'h00011000) begin nerr++; $display("FAIL single_k got %h exp 00011000", k_out); end
    nvec++; if (step_count !== 16'd1) begin nerr++; $display("FAIL single_steps got %0d exp 1", step_count); end
    nvec++; if (upd_rsp.size() != 1 || upd_rsp[0] != N) begin nerr++; $display("FAIL single_rsp got %0d exp %0d", upd_rsp.size() ? upd_rsp[0] : -1, N); end
  endtask

  task automatic test_backpressure();
    int bad;
    run(1, $urandom, 32'h100, 32'h7FFFFFFF, 2, 1, 0, 0, 0);
    bad = (acc_idx.size() != N);
    for (int i = 0; i < acc_idx.size(); i++)
      if (acc_idx[i] != i) bad++;
    nvec++; if (bad != 0) begin nerr++; $display("FAIL bp_order got %0d errors exp 0", bad); end
    nvec++; if (hold_err != 0) begin nerr++; $display("FAIL bp_hold got %0d errors exp 0", hold_err); end
    nvec++; if (upd_rsp.size() != 1 || upd_rsp[0] != N) begin nerr++; $display("FAIL bp_rsp got %0d exp %0d", upd_rsp.size() ? upd_rsp[0] : -1, N); end
    nvec++; if (done_cnt != 1 || timed_out) begin nerr++; $display("FAIL bp_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_clamp_saturate();
    logic [31:0] exp_ks[4];
    exp_ks = '{32'h18000, 32'h20000, 32'h20000, 32'h20000};
    run(4, 32'h0, 32'h8000, 32'h20000, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (upd_ks.size() != 4 || upd_ks[i] !== exp_ks[i]) begin
        nerr++;
        $display("FAIL clamp_ks[%0d] got %h exp %h", i, upd_ks.size() > i ? upd_ks[i] : 32'hx, exp_ks[i]);
      end
    end
    nvec++; if (done_cyc != 73) begin nerr++; $display("FAIL clamp_done_cycle got %0d exp 73", done_cyc); end
    run(3, 32'h7FFFFFFF, 32'h0, 32'h7FFFFFFF, 1, 0, 0, 0, 0);
    nvec++; if (k_out !== 32'h7FFFFFFF) begin nerr++; $display("FAIL sat_k got %h exp 7fffffff", k_out); end
  endtask

  task automatic test_abort();
    run(4, 32'h1000, 32'h1000, 32'h7FFFFFFF, 3, 0, 0, 2 * N, 0);
    nvec++; if (abort_cnt != 1 || timed_out) begin nerr++; $display("FAIL abort_pulse got %0d exp 1", abort_cnt); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL abort_busy got %b exp 0", busy); end
    nvec++; if (step_count !== 16'd1 || upd_cyc.size() != 1) begin nerr++; $display("FAIL abort_steps got %0d exp 1", step_count); end
    repeat (30) @(negedge clk);
    nvec++; if (done_cnt != 0) begin nerr++; $display("FAIL abort_done got %0d exp 0", done_cnt); end
    nvec++; if (acc_idx.size() != 2 * N) begin nerr++; $display("FAIL abort_reqs got %0d exp %0d", acc_idx.size(), 2 * N); end
  endtask

  task automatic test_zero_and_overflow();
    run(0, 32'h1000, 32'h1000, 32'h7FFFFFFF, 1, 0, 0, 0, 0);
    nvec++; if (done_cyc != 1) begin nerr++; $display("FAIL zero_done_cycle got %0d exp 1", done_cyc); end
    nvec++; if (acc_idx.size() != 0) begin nerr++; $display("FAIL zero_reqs got %0d exp 0", acc_idx.size()); end
    nvec++; if (k_out !== 32'h10000 || step_count !== 16'd0) begin nerr++; $display("FAIL zero_state got %h/%0d exp 00010000/0", k_out, step_count); end
    run(1, 32'h1000, 32'h0, 32'h7FFFFFFF, 1, 0, 0, 0, 1);
    nvec++; if (rsp_overflow !== 1'b1) begin nerr++; $display("FAIL ovf_set got %b exp 1", rsp_overflow); end
    nvec++; if (done_cnt != 1 || step_count !== 16'd1) begin nerr++; $display("FAIL ovf_step got %0d exp 1", step_count); end
    repeat (5) @(negedge clk);
    nvec++; if (rsp_overflow !== 1'b1) begin nerr++; $display("FAIL ovf_sticky got %b exp 1", rsp_overflow); end
    run(1, 32'h1000, 32'h0, 32'h7FFFFFFF, 1, 0, 0, 0, 0);
    nvec++; if (rsp_overflow !== 1'b0) begin nerr++; $display("FAIL ovf_clear got %b exp 0", rsp_overflow); end
  endtask

  task automatic test_random();
    int ns, l, bad;
    logic [31:0] ki, ksi, ksm;
    for (int it = 0; it < 6; it++) begin
      ns  = $urandom_range(1, 4);
      l   = $urandom_range(1, 4);
      ki  = (it % 2 == 0) ? $urandom : $urandom_range(0, 32'h4000) - 32'h2000;
      ksi = $urandom_range(0, 32'h10000);
      ksm = $urandom_range(0, 32'h40000);
      run(ns, ki, ksi, ksm, l, 2, 5, 0, 0);
      nvec++; if (timed_out || done_cnt != 1) begin nerr++; $display("FAIL rnd%0d_done got %0d exp 1", it, done_cnt); end
      nvec++; if (step_count !== 16'(ns)) begin nerr++; $display("FAIL rnd%0d_steps got %0d exp %0d", it, step_count, ns); end
      nvec++; if (k_out !== ref_k(ki, ns)) begin nerr++; $display("FAIL rnd%0d_k got %h exp %h", it, k_out, ref_k(ki, ns)); end
      nvec++; if (ks_out !== ref_ks(ksi, ksm, ns)) begin nerr++; $display("FAIL rnd%0d_ks got %h exp %h", it, ks_out, ref_ks(ksi, ksm, ns)); end
      bad = (acc_idx.size() != N * ns);
      for (int i = 0; i < acc_idx.size(); i++)
        if (acc_idx[i] != i % N) bad++;
      nvec++; if (bad != 0) begin nerr++; $display("FAIL rnd%0d_order got %0d errors exp 0", it, bad); end
      bad = (upd_k.size() != ns) + (upd_rsp.size() != ns);
      for (int i = 0; i < upd_k.size() && i < upd_rsp.size(); i++) begin
        if (upd_k[i] !== ref_k(ki, i + 1)) bad++;
        if (upd_ks[i] !== ref_ks(ksi, ksm, i + 1)) bad++;
        if (upd_sc[i] != i + 1 || upd_rsp[i] != N) bad++;
      end
      nvec++; if (bad != 0) begin nerr++; $display("FAIL rnd%0d_steps_trace got %0d errors exp 0", it, bad); end
      nvec++; if (hold_err != 0) begin nerr++; $display("FAIL rnd%0d_hold got %0d errors exp 0", it, hold_err); end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single_step();
    test_backpressure();
    test_clamp_saturate();
    test_abort();
    test_zero_and_overflow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
